// File: rtl/hc595_sync_if.sv
// rtl/hc595_sync_if.sv - serial/control/status bundle for the hc595_sync shift/storage register
//
// Signals:
//   ser        serial data into stage 0
//   sh_en      shift enable
//   st_en      store enable (shift register -> storage register)
//   srclr_n    synchronous active-low clear of shift register and bit counter
//   oe_n       active-low output enable for the parallel q bus
//   q7s        serial cascade out (last shift stage)
//   frame_rdy  a full frame of WIDTH bits has been shifted in
//
// master: the controller driving the register; slave: hc595_sync itself.
interface hc595_sync_if;
    logic ser;
    logic sh_en;
    logic st_en;
    logic srclr_n;
    logic oe_n;
    logic q7s;
    logic frame_rdy;

    modport master (
        output ser,
        output sh_en,
        output st_en,
        output srclr_n,
        output oe_n,
        input  q7s,
        input  frame_rdy
    );

    modport slave (
        input  ser,
        input  sh_en,
        input  st_en,
        input  srclr_n,
        input  oe_n,
        output q7s,
        output frame_rdy
    );
endinterface

// File: rtl/hc595_sync.sv
// rtl/hc595_sync.sv - synchronous 595-style shift register with storage register, tri-state q and frame counter
//
// Parameters:
//   WIDTH      number of shift/storage stages, legal range 2..16
//
// Ports:
//   clk        single clock, all state changes on its rising edge
//   rst_n      asynchronous active-low reset of all state
//   bus        hc595_sync_if.slave: ser, sh_en, st_en, srclr_n, oe_n in; q7s, frame_rdy out
//   q          storage register contents, high-impedance while oe_n=1
//
// q is kept as a plain port rather than an interface member so its
// high-impedance drive resolves at this module's boundary.
module hc595_sync #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    hc595_sync_if.slave      bus,
    output wire [WIDTH-1:0]  q
);

    localparam int            CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [WIDTH-1:0] streg;
    logic [CW-1:0]    bit_cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             frame_q;

    // Next shift-register and counter values. Clear dominates everything.
    // A store restarts the frame count; if a shift happens on the same
    // edge, that shifted bit is the first bit of the new frame.
    always_comb begin
        sreg_nxt = sreg;
        cnt_nxt  = bit_cnt;
        if (!bus.srclr_n) begin
            sreg_nxt = '0;
            cnt_nxt  = '0;
        end else begin
            if (bus.sh_en) begin
                sreg_nxt = {sreg[WIDTH-2:0], bus.ser};
            end
            if (bus.st_en) begin
                cnt_nxt = bus.sh_en ? CW'(1) : '0;
            end else if (bus.sh_en && (bit_cnt != FULL)) begin
                // Saturate at WIDTH: data keeps shifting but the count stops.
                cnt_nxt = bit_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            streg   <= '0;
            bit_cnt <= '0;
            frame_q <= 1'b0;
        end else begin
            sreg    <= sreg_nxt;
            bit_cnt <= cnt_nxt;
            // Flag derived from the next count so it tracks bit_cnt==WIDTH
            // exactly while coming straight from a flop.
            frame_q <= (cnt_nxt == FULL);
            // Storage samples the pre-edge shift register, so a shift or a
            // clear on the same edge is not seen until the next store.
            if (bus.st_en) begin
                streg <= sreg;
            end
        end
    end

    assign q             = bus.oe_n ? {WIDTH{1'bz}} : streg;
    assign bus.q7s       = sreg[WIDTH-1];
    assign bus.frame_rdy = frame_q;

endmodule

// File: tb/tb_hc595_sync.sv
// tb/tb_hc595_sync.sv - self-checking bench for hc595_sync against a behavioural model
module tb_hc595_sync;

    localparam int W    = 8;
    localparam int MASK = (1 << W) - 1;

    logic         clk;
    logic         rst_n;
    wire  [W-1:0] q;

    hc595_sync_if bus ();

    hc595_sync #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .q     (q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fails  = 0;

    // Behavioural model: integers and plain arithmetic
    int m_sreg  = 0;
    int m_streg = 0;
    int m_cnt   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sreg  = 0;
        m_streg = 0;
        m_cnt   = 0;
    endtask

    // Present inputs, advance the model, clock once, sample #1 after the edge.
    task automatic step(input logic ser, input logic sh, input logic st, input logic clr_n);
        int old;
        bus.ser     = ser;
        bus.sh_en   = sh;
        bus.st_en   = st;
        bus.srclr_n = clr_n;
        old = m_sreg;
        if (!clr_n) begin
            m_sreg = 0;
            m_cnt  = 0;
        end else begin
            if (sh) m_sreg = ((m_sreg * 2) + int'(ser)) & MASK;
            if (st) m_cnt = sh ? 1 : 0;
            else if (sh) m_cnt = (m_cnt + 1 > W) ? W : m_cnt + 1;
        end
        if (st) m_streg = old;
        @(posedge clk);
        #1;
        bus.sh_en   = 1'b0;
        bus.st_en   = 1'b0;
        bus.srclr_n = 1'b1;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".sreg"}, 32'(dut.sreg), m_sreg);
        check({tag, ".cnt"}, 32'(dut.bit_cnt), m_cnt);
        check({tag, ".q7s"}, 32'(bus.q7s), (m_sreg >> (W - 1)) & 1);
        check({tag, ".frame_rdy"}, 32'(bus.frame_rdy), (m_cnt == W) ? 1 : 0);
        if (bus.oe_n == 1'b0)
            check({tag, ".q"}, 32'(q), m_streg);
        else if (m_streg != 0)
            check({tag, ".q_off"}, 32'(q !== W'(m_streg)), 1);
    endtask

    task automatic shift_byte(input logic [W-1:0] v, input string tag);
        for (int i = W - 1; i >= 0; i--) begin
            step(v[i], 1'b1, 1'b0, 1'b1);
            check_all(tag);
        end
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".q"}, 32'(q), 0);
        check({tag, ".q7s"}, 32'(bus.q7s), 0);
        check({tag, ".frame_rdy"}, 32'(bus.frame_rdy), 0);
        check({tag, ".cnt"}, 32'(dut.bit_cnt), 0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b1;
        bus.ser     = 1'b0;
        bus.sh_en   = 1'b0;
        bus.st_en   = 1'b0;
        bus.srclr_n = 1'b1;
        bus.oe_n    = 1'b0;
        #1;
        async_reset("reset");

        // Known frame A3, then store
        shift_byte(8'hA3, "a3_shift");
        check("a3.sreg_const", 32'(dut.sreg), 32'hA3);
        check("a3.frame_const", 32'(bus.frame_rdy), 1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_all("a3_store");
        check("a3.q_const", 32'(q), 32'hA3);
        check("a3.frame_after_store", 32'(bus.frame_rdy), 0);

        // Store with simultaneous shift from streg=0
        async_reset("reset2");
        shift_byte(8'hA3, "lag_shift");
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check_all("lag");
        check("lag.q_const", 32'(q), 32'hA3);
        check("lag.sreg_const", 32'(dut.sreg), 32'h46);
        check("lag.cnt_const", 32'(dut.bit_cnt), 1);

        // Clear with shift and store on the same edge
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check_all("clr0");
        shift_byte(8'h5C, "c5_shift");
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check_all("clr_st");
        check("clr_st.q_const", 32'(q), 32'h5C);
        check("clr_st.sreg_const", 32'(dut.sreg), 0);

        // Output enable is combinational
        shift_byte(8'hA3, "oe_shift");
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check_all("oe_store");
        bus.oe_n = 1'b1;
        #1;
        check_all("oe_off");
        check("oe_off.q7s", 32'(bus.q7s), 1);
        bus.oe_n = 1'b0;
        #1;
        check("oe_on.q_const", 32'(q), 32'hA3);

        // Reset mid-frame, then count from scratch and saturate
        async_reset("reset3");
        for (int i = 0; i < 4; i++) begin
            step(1'($urandom), 1'b1, 1'b0, 1'b1);
            check_all("pre_rst");
        end
        async_reset("midframe_rst");
        for (int i = 1; i <= 12; i++) begin
            step(1'($urandom), 1'b1, 1'b0, 1'b1);
            check_all("post_rst");
            check("post_rst.frame_const", 32'(bus.frame_rdy), (i >= 8) ? 1 : 0);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic ser, sh, st, clr_n;
            ser   = 1'($urandom);
            sh    = ($urandom_range(0, 3) != 0);
            st    = ($urandom_range(0, 5) == 0);
            clr_n = ($urandom_range(0, 11) != 0);
            bus.oe_n = ($urandom_range(0, 4) == 0);
            step(ser, sh, st, clr_n);
            check_all("rand");
            if ($urandom_range(0, 49) == 0) async_reset("rand_rst");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/hc595_sync.md
HC595_SYNC -- requirements
Module: hc595_sync

Interface
REQ-001 Parameter WIDTH, default 8: number of shift/storage stages (legal range 2..16).
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ser  input  1  serial data in; enters stage 0 on a shift.
REQ-005 sh_en  input  1  shift enable, sampled on rising clk.
REQ-006 st_en  input  1  store enable: copies shift register to storage register, sampled on rising clk.
REQ-007 srclr_n  input  1  synchronous active-low clear of shift register and bit counter.
REQ-008 oe_n  input  1  active-low output enable for q.
REQ-009 q  output  WIDTH  storage register contents; drives gate inputs downstream (e.g. hc08 pa/pb).
REQ-010 q7s  output  1  serial cascade out = shift stage WIDTH-1, always driven, unaffected by oe_n.
REQ-011 frame_rdy  output  1  high when WIDTH bits have been shifted since the last clear/store.

Function
REQ-012 The shift register (sreg) SHALL, on a clk edge with sh_en=1 and srclr_n=1, load sreg <= {sreg[WIDTH-2:0], ser}.
REQ-013 With sh_en=0 and srclr_n=1, sreg SHALL hold.
REQ-014 With srclr_n=0, sreg SHALL become all zeros on that edge, overriding sh_en.
REQ-015 The storage register (streg) SHALL load the pre-edge value of sreg on an edge with st_en=1, else hold.
REQ-016 sh_en=1 and st_en=1 on the same edge: streg SHALL capture sreg as it was before the shift (one-stage lag).
REQ-017 srclr_n=0 and st_en=1 on the same edge: streg SHALL capture the pre-clear sreg; sreg clears.
REQ-018 q SHALL equal streg when oe_n=0 and SHALL be all high-impedance when oe_n=1; oe_n is combinational, zero latency.
REQ-019 q7s SHALL equal sreg[WIDTH-1] combinationally from the register.
REQ-020 A bit counter (bit_cnt, width clog2(WIDTH+1)) SHALL increment by 1 per shift and saturate at WIDTH (no wrap).
REQ-021 bit_cnt SHALL go to 0 on srclr_n=0, and on st_en=1 without a simultaneous shift.
REQ-022 st_en=1 with sh_en=1 (srclr_n=1) SHALL set bit_cnt to 1; srclr_n=0 always forces 0.
REQ-023 frame_rdy SHALL be registered-equivalent: high exactly while bit_cnt==WIDTH.
REQ-024 Latency: a bit on ser reaches q7s after WIDTH shifts; streg is visible on q one edge after st_en.
REQ-025 Further shifts after saturation SHALL keep shifting data (oldest bit leaves via q7s) while frame_rdy stays 1.

Reset
REQ-026 rst_n=0 SHALL immediately, without a clock, force sreg=0, streg=0, bit_cnt=0, giving q=0 (when oe_n=0), q7s=0, frame_rdy=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; after release the first shift counts as bit 1.
REQ-028 Deassertion SHALL take effect on the first clk edge after rst_n rises; no input is sampled while rst_n=0.

Verification
REQ-029 Reset, oe_n=0: rst_n low -> q=8'h00, q7s=0, frame_rdy=0 before any clk edge.
REQ-030 Shift ser=1,0,1,0,0,0,1,1 with sh_en=1 over 8 edges -> sreg=8'hA3, q7s=1, frame_rdy=1 after edge 8; pulse st_en -> q=8'hA3 next edge, frame_rdy=0.
REQ-031 With sreg=8'hA3 and streg=8'h00: sh_en=1, st_en=1, ser=0 same edge -> q=8'hA3, sreg=8'h46, bit_cnt=1.
REQ-032 srclr_n=0 with sh_en=1, st_en=1 at sreg=8'h5C -> sreg=0, bit_cnt=0, q=8'h5C.
REQ-033 Toggle oe_n with q=8'hA3 -> q=8'hzz while oe_n=1, returns to 8'hA3 with no clock edge; q7s unaffected.
REQ-034 Assert rst_n low after 4 shifts, release, shift 8 more bits -> frame_rdy rises only after the 8th post-reset shift; 12 total shifts without store -> frame_rdy stays 1, no wrap to 0.
